axi4_wr_slave_mem: RTL and testbench

- AXI4 write-only responder: the slave end of the `axi4_if` write channels (AW/W/B).
- Accepts INCR bursts into an internal word-addressed memory and returns a write response per burst.
- Provides a registered side read port so the SoC and bench can inspect written data.
- Sits behind the AXI4 write master: DMA or stream-to-memory path.

---
 rtl/params_pkg.sv | 12 +
 rtl/axi4_if.sv | 28 ++
 rtl/sdp_ram.sv | 33 +++
 rtl/axi4_wr_slave_mem.sv | 156 +++++++++++++++
 tb/tb_axi4_wr_slave_mem.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/params_pkg.sv
// Shared AXI4 widths, response codes and write-slave state encoding.
// Pure definitions: no latency or backpressure of its own.
// Imported by the AXI4 interface and the write-slave memory.
package params_pkg;
    localparam int AXI4_ADDR_W = 32;
    localparam int AXI4_DATA_W = 32;

    localparam logic [1:0] AXI4_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI4_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WS_IDLE, WS_DATA, WS_RESP} axi4_wr_slv_state_e;
endpackage

// File: rtl/axi4_if.sv
// AXI4 write-channel bundle (AW/W/B) with master and slave views.
// Wires only: no latency.
// valid/ready handshake on every channel.
interface axi4_if;
    import params_pkg::*;

    logic [AXI4_ADDR_W-1:0] awaddr;
    logic [7:0]             awlen;
    logic                   awvalid;
    logic                   awready;
    logic [AXI4_DATA_W-1:0] wdata;
    logic                   wlast;
    logic                   wvalid;
    logic                   wready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;

    modport slave (
        input  awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
        output awready, wready, bresp, bvalid
    );

    modport master (
        output awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Read data valid one cycle after re; a same-cycle write to that word returns old data.
// No backpressure; rdata holds while re is low.
module sdp_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Array itself is never reset so it can map onto RAM macros.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/axi4_wr_slave_mem.sv
// AXI4 INCR write slave into a word memory with a side read port; stats under AXI4_WR_SLV_STATS_EN.
// Latency: AW hs -> wready +1, last W beat -> bvalid +1, B hs -> awready +1; side read +1.
// Backpressure: one burst in flight; bvalid/bresp held until bready, W stalls freely on wvalid.
module axi4_wr_slave_mem
    import params_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    axi4_if.slave                    s_axi,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [AXI4_DATA_W-1:0]   rd_data,
    output logic [15:0]              burst_cnt,
    output logic [15:0]              err_cnt
);
    localparam int ADDR_LSB = $clog2(AXI4_DATA_W/8);
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int WIDX_W   = AXI4_ADDR_W - ADDR_LSB;

    axi4_wr_slv_state_e state_q, state_d;
    logic [WIDX_W-1:0]  idx_q, idx_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         beat_q, beat_d;
    logic               err_q, err_d, err_nxt;
    logic               awready_q, awready_d;
    logic               wready_q, wready_d;
    logic               bvalid_q, bvalid_d;
    logic [1:0]         bresp_q, bresp_d;
    logic               mem_we;
    logic               in_range;
    logic               last_beat;
    logic               aw_hs, w_hs, b_hs;

    assign aw_hs     = s_axi.awvalid && awready_q;
    assign w_hs      = s_axi.wvalid && wready_q;
    assign b_hs      = bvalid_q && s_axi.bready;
    // Full-width index compare: high address bits must not alias into the array.
    assign in_range  = (idx_q >> IDX_W) == '0;
    assign last_beat = (beat_q == len_q);

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        beat_d    = beat_q;
        err_d     = err_q;
        err_nxt   = err_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        case (state_q)
            WS_IDLE: begin
                awready_d = 1'b1;
                if (aw_hs) begin
                    idx_d     = WIDX_W'(s_axi.awaddr >> ADDR_LSB);
                    len_d     = s_axi.awlen;
                    beat_d    = '0;
                    err_d     = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    state_d   = WS_DATA;
                end
            end
            WS_DATA: begin
                if (w_hs) begin
                    mem_we  = in_range;
                    err_nxt = err_q | ~in_range | (s_axi.wlast != last_beat);
                    err_d   = err_nxt;
                    idx_d   = idx_q + WIDX_W'(1);
                    beat_d  = beat_q + 8'd1;
                    // awlen alone ends the burst; a misplaced wlast only flags SLVERR.
                    if (last_beat) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bresp_d  = err_nxt ? AXI4_RESP_SLVERR : AXI4_RESP_OKAY;
                        state_d  = WS_RESP;
                    end
                end
            end
            WS_RESP: begin
                if (b_hs) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    state_d   = WS_IDLE;
                end
            end
            default: state_d = WS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= WS_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= AXI4_RESP_OKAY;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    sdp_ram #(
        .DEPTH (DEPTH),
        .WIDTH (AXI4_DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (idx_q[IDX_W-1:0]),
        .wdata (s_axi.wdata),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

`ifdef AXI4_WR_SLV_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt <= '0;
            err_cnt   <= '0;
        end else if (b_hs) begin
            if (burst_cnt != 16'hFFFF) begin
                burst_cnt <= burst_cnt + 16'd1;
            end
            if (bresp_q == AXI4_RESP_SLVERR && err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`else
    assign burst_cnt = '0;
    assign err_cnt   = '0;
`endif
endmodule

// File: tb/tb_axi4_wr_slave_mem.sv
// Directed bench for axi4_wr_slave_mem: table of single-beat writes plus burst corner sequences.
module tb_axi4_wr_slave_mem;
    import params_pkg::*;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic [15:0] burst_cnt;
    logic [15:0] err_cnt;

    axi4_if axi ();

    axi4_wr_slave_mem #(.DEPTH(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_axi     (axi.slave),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .burst_cnt (burst_cnt),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [7:0]  rd_idx;
        logic [31:0] rd_exp;
    } vec_t;

    vec_t vecs [8];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_b  = 0;
    int   exp_e  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stats();
`ifdef AXI4_WR_SLV_STATS_EN
        chk("burst_cnt", {16'h0, burst_cnt}, exp_b);
        chk("err_cnt", {16'h0, err_cnt}, exp_e);
`else
        chk("burst_cnt", {16'h0, burst_cnt}, 32'h0);
        chk("err_cnt", {16'h0, err_cnt}, 32'h0);
`endif
    endtask

    task automatic do_aw(input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        while (axi.awready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("awready_wait", {31'h0, axi.awready}, 32'h1);
        axi.awaddr  = addr;
        axi.awlen   = len;
        axi.awvalid = 1'b1;
        tick();
        axi.awvalid = 1'b0;
        chk("aw_wready_lat", {31'h0, axi.wready}, 32'h1);
        chk("aw_awready_drop", {31'h0, axi.awready}, 32'h0);
    endtask

    task automatic do_w(input logic [31:0] data, input logic last, input int gap);
        axi.wvalid = 1'b0;
        for (int i = 0; i < gap; i++) tick();
        chk("w_wready", {31'h0, axi.wready}, 32'h1);
        axi.wdata  = data;
        axi.wlast  = last;
        axi.wvalid = 1'b1;
        tick();
        axi.wvalid = 1'b0;
    endtask

    task automatic do_b(input logic [1:0] resp, input int hold);
        chk("bvalid_lat", {31'h0, axi.bvalid}, 32'h1);
        chk("bresp", {30'h0, axi.bresp}, {30'h0, resp});
        chk("b_wready_low", {31'h0, axi.wready}, 32'h0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("bvalid_hold", {31'h0, axi.bvalid}, 32'h1);
            chk("bresp_hold", {30'h0, axi.bresp}, {30'h0, resp});
        end
        axi.bready = 1'b1;
        tick();
        axi.bready = 1'b0;
        exp_b++;
        if (resp == AXI4_RESP_SLVERR) exp_e++;
        chk("b_bvalid_drop", {31'h0, axi.bvalid}, 32'h0);
        chk("b_awready_lat", {31'h0, axi.awready}, 32'h1);
        chk_stats();
    endtask

    task automatic rd(input logic [7:0] idx, input logic [31:0] exp);
        rd_en   = 1'b1;
        rd_addr = idx;
        tick();
        rd_en = 1'b0;
        chk("rd_data", rd_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h1111_1111, AXI4_RESP_OKAY,   8'd0,   32'h1111_1111};
        vecs[1] = '{32'h0000_0004, 32'h2222_2222, AXI4_RESP_OKAY,   8'd1,   32'h2222_2222};
        vecs[2] = '{32'h0000_0008, 32'h3333_3333, AXI4_RESP_OKAY,   8'd2,   32'h3333_3333};
        vecs[3] = '{32'h0000_000C, 32'h4444_4444, AXI4_RESP_OKAY,   8'd3,   32'h4444_4444};
        vecs[4] = '{32'h0000_03FC, 32'h5A5A_5A5A, AXI4_RESP_OKAY,   8'd255, 32'h5A5A_5A5A};
        vecs[5] = '{32'h0000_0400, 32'h9999_9999, AXI4_RESP_SLVERR, 8'd0,   32'h1111_1111};
        vecs[6] = '{32'hFFFF_FFFC, 32'h8888_8888, AXI4_RESP_SLVERR, 8'd255, 32'h5A5A_5A5A};
        vecs[7] = '{32'h0000_0013, 32'h0BAD_C0DE, AXI4_RESP_OKAY,   8'd4,   32'h0BAD_C0DE};

        rst         = 1'b1;
        rd_en       = 1'b0;
        rd_addr     = '0;
        axi.awaddr  = '0;
        axi.awlen   = '0;
        axi.awvalid = 1'b0;
        axi.wdata   = '0;
        axi.wlast   = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_awready", {31'h0, axi.awready}, 32'h0);
        chk("rst_wready", {31'h0, axi.wready}, 32'h0);
        chk("rst_bvalid", {31'h0, axi.bvalid}, 32'h0);
        chk("rst_bresp", {30'h0, axi.bresp}, 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk_stats();
        rst = 1'b0;
        tick();
        chk("post_rst_awready", {31'h0, axi.awready}, 32'h1);

        // Table of single-beat writes with readback
        for (int i = 0; i < 8; i++) begin
            do_aw(vecs[i].addr, 8'd0);
            do_w(vecs[i].data, 1'b1, 0);
            do_b(vecs[i].resp, 0);
            rd(vecs[i].rd_idx, vecs[i].rd_exp);
        end

        // Single beat to word 4, rd_data holds when rd_en low
        do_aw(32'h10, 8'd0);
        do_w(32'hDEAD_BEEF, 1'b1, 0);
        do_b(AXI4_RESP_OKAY, 0);
        rd(8'd4, 32'hDEAD_BEEF);
        rd_addr = 8'd0;
        tick();
        chk("rd_hold", rd_data, 32'hDEAD_BEEF);

        // W gaps and B backpressure
        do_aw(32'h100, 8'd3);
        do_w(32'd1, 1'b0, 0);
        do_w(32'd2, 1'b0, 2);
        do_w(32'd3, 1'b0, 2);
        chk("bp_no_early_b", {31'h0, axi.bvalid}, 32'h0);
        do_w(32'd4, 1'b1, 2);
        do_b(AXI4_RESP_OKAY, 3);
        for (int i = 0; i < 4; i++) rd(8'(8'h40 + i), 32'(i + 1));

        // Burst running off the end of memory
        do_aw(32'h3F8, 8'd3);
        do_w(32'hA, 1'b0, 0);
        do_w(32'hB, 1'b0, 0);
        do_w(32'hC, 1'b0, 0);
        do_w(32'hD, 1'b1, 0);
        do_b(AXI4_RESP_SLVERR, 0);
        rd(8'd254, 32'hA);
        rd(8'd255, 32'hB);
        for (int i = 0; i < 4; i++) rd(8'(i), vecs[i].data);

        // Early wlast: burst still runs to awlen
        do_aw(32'h200, 8'd2);
        do_w(32'h70, 1'b0, 0);
        do_w(32'h71, 1'b1, 0);
        chk("wlast_no_early_b", {31'h0, axi.bvalid}, 32'h0);
        chk("wlast_wready_on", {31'h0, axi.wready}, 32'h1);
        do_w(32'h72, 1'b0, 0);
        do_b(AXI4_RESP_SLVERR, 0);
        rd(8'd128, 32'h70);
        rd(8'd129, 32'h71);
        rd(8'd130, 32'h72);

        // Reset after 2 of 4 beats
        do_aw(32'h300, 8'd3);
        do_w(32'h100, 1'b0, 0);
        do_w(32'h101, 1'b0, 0);
        rst = 1'b1;
        #1;
        exp_b = 0;
        exp_e = 0;
        chk("mid_rst_awready", {31'h0, axi.awready}, 32'h0);
        chk("mid_rst_wready", {31'h0, axi.wready}, 32'h0);
        chk("mid_rst_bvalid", {31'h0, axi.bvalid}, 32'h0);
        chk_stats();
        tick();
        rst = 1'b0;
        tick();
        chk("rel_awready", {31'h0, axi.awready}, 32'h1);
        chk("rel_bvalid", {31'h0, axi.bvalid}, 32'h0);
        rd(8'hC0, 32'h100);
        rd(8'hC1, 32'h101);
        do_aw(32'h20, 8'd0);
        do_w(32'h77, 1'b1, 0);
        do_b(AXI4_RESP_OKAY, 0);
        rd(8'd8, 32'h77);

        // Same-cycle write and side read of word 1: old data first
        do_aw(32'h4, 8'd0);
        rd_en   = 1'b1;
        rd_addr = 8'd1;
        do_w(32'hCAFE_F00D, 1'b1, 0);
        rd_en = 1'b0;
        chk("rbw_old", rd_data, 32'h2222_2222);
        do_b(AXI4_RESP_OKAY, 0);
        rd(8'd1, 32'hCAFE_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
